axis_packet_fifo: RTL and testbench

- AXI-stream FIFO placed directly downstream of the 2:1 stream mux. Buffers the mux's 8-bit data/last output and decouples it from downstream backpressure.
- Optional store-and-forward mode presents only complete packets (terminated by last) to the consumer.
- Exposes occupancy and stored-packet counts for status and debug.

---
 rtl/axis_packet_fifo.sv | 113 +++++++++++
 tb/tb_axis_packet_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: first-word-fall-through AXI-stream FIFO that stores {last, data}.
// It can run cut-through, or store-and-forward, where only complete packets are
// presented to the consumer.
// Also reports word occupancy and the number of stored packet terminators.
module axis_packet_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int PKT_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   pkt_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_C   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   ZERO_C  = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR1_C  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH:0]   mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   pkt_count_r;
    logic                  active_r;   // low during reset, high from the first edge after release
    logic                  cut_r;      // oversize packet is draining cut-through (packet mode)

    logic full_s;
    logic wr_en_s;
    logic rd_en_s;
    logic head_last_s;
    logic m_valid_s;

    assign full_s      = (count_r == DEPTH_C);
    assign s_ready     = active_r & ~full_s;
    assign wr_en_s     = s_valid & s_ready;
    assign rd_en_s     = m_valid_s & m_ready;
    assign head_last_s = mem_r[rd_ptr_r][DATA_WIDTH];
    assign m_data      = mem_r[rd_ptr_r][DATA_WIDTH-1:0];
    assign m_last      = head_last_s;
    assign m_valid     = m_valid_s;
    assign count       = count_r;
    assign pkt_count   = pkt_count_r;

    // Decide whether the head word may be presented to the consumer.
    always_comb begin
        m_valid_s = 1'b0;
        if (count_r == ZERO_C) begin
            m_valid_s = 1'b0;
        end else if (PKT_MODE == 0) begin
            m_valid_s = 1'b1;
        end else begin
            // A full FIFO with no terminator would deadlock, so it starts a
            // sticky cut-through drain that lasts until that packet's last is read.
            m_valid_s = (pkt_count_r != ZERO_C) | full_s | cut_r;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {s_last, s_data};
        end
    end

    // Pointers, occupancy, packet count and control flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            pkt_count_r <= '0;
            active_r    <= 1'b0;
            cut_r       <= 1'b0;
        end else begin
            active_r <= 1'b1;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR1_C;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR1_C;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
            case ({wr_en_s & s_last, rd_en_s & head_last_s})
                2'b10:   pkt_count_r <= pkt_count_r + ONE_C;
                2'b01:   pkt_count_r <= pkt_count_r - ONE_C;
                default: pkt_count_r <= pkt_count_r;
            endcase
            if (PKT_MODE != 0) begin
                if (rd_en_s & head_last_s) begin
                    cut_r <= 1'b0;
                end else if (full_s) begin
                    cut_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Self-checking bench for axis_packet_fifo: one cut-through and one
// store-and-forward instance, each compared every cycle against a queue model.
module tb_axis_packet_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data    [2];
    logic       s_valid   [2];
    logic       s_ready   [2];
    logic       s_last    [2];
    logic [7:0] m_data    [2];
    logic       m_valid   [2];
    logic       m_ready   [2];
    logic       m_last    [2];
    logic [4:0] count     [2];
    logic [4:0] pkt_count [2];

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of {last, data} per instance.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit         act  = 1'b0;
    bit         cut1 = 1'b0;

    always #5 clk = ~clk;

    axis_packet_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .PKT_MODE(0)) dut0 (
        .clk(clk), .reset(reset),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_last(s_last[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_last(m_last[0]),
        .count(count[0]), .pkt_count(pkt_count[0])
    );

    axis_packet_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .PKT_MODE(1)) dut1 (
        .clk(clk), .reset(reset),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_last(s_last[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_last(m_last[1]),
        .count(count[1]), .pkt_count(pkt_count[1])
    );

    function automatic int sz(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int lasts(input int i);
        int n = 0;
        if (i == 0) begin
            foreach (q0[k]) n += int'(q0[k][8]);
        end else begin
            foreach (q1[k]) n += int'(q1[k][8]);
        end
        return n;
    endfunction

    function automatic logic [8:0] head(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic bit exp_valid(input int i);
        if (sz(i) == 0) return 1'b0;
        if (i == 0) return 1'b1;
        return (lasts(1) != 0) || (sz(1) == 16) || cut1;
    endfunction

    function automatic bit exp_ready(input int i);
        return act && (sz(i) < 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input int i);
        logic [8:0] h;
        chk($sformatf("count%0d", i), 32'(count[i]), 32'(sz(i)));
        chk($sformatf("pkt_count%0d", i), 32'(pkt_count[i]), 32'(lasts(i)));
        chk($sformatf("m_valid%0d", i), 32'(m_valid[i]), 32'(exp_valid(i)));
        chk($sformatf("s_ready%0d", i), 32'(s_ready[i]), 32'(exp_ready(i)));
        if (exp_valid(i)) begin
            h = head(i);
            chk($sformatf("m_data%0d", i), 32'(m_data[i]), 32'(h[7:0]));
            chk($sformatf("m_last%0d", i), 32'(m_last[i]), 32'(h[8]));
        end
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        act  = 1'b0;
        cut1 = 1'b0;
    endtask

    // One clock: check outputs, take the edge, apply the handshakes to the model.
    task automatic step();
        bit wr [2];
        bit rd [2];
        int before1;
        logic [8:0] popped;
        for (int i = 0; i < 2; i++) begin
            check_outputs(i);
            wr[i] = s_valid[i] && exp_ready(i);
            rd[i] = m_ready[i] && exp_valid(i);
        end
        before1 = sz(1);
        @(posedge clk);
        if (reset) begin
            clear_model();
        end else begin
            act = 1'b1;
            if (rd[0]) void'(q0.pop_front());
            if (wr[0]) q0.push_back({s_last[0], s_data[0]});
            popped = 9'h000;
            if (rd[1]) popped = q1.pop_front();
            if (rd[1] && popped[8]) cut1 = 1'b0;
            else if (before1 == 16) cut1 = 1'b1;
            if (wr[1]) q1.push_back({s_last[1], s_data[1]});
        end
        @(negedge clk);
    endtask

    task automatic drive(input int i, input bit v, input logic [7:0] d, input bit l);
        s_valid[i] = v;
        s_data[i]  = d;
        s_last[i]  = l;
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] stream [3];
        int guard;
        bit acc;
        stream[0] = 8'h23;
        stream[1] = 8'h45;
        stream[2] = 8'h67;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b0, 8'h00, 1'b0);
            m_ready[i] = 1'b0;
        end
        clear_model();

        // Reset held for 30 ns, then idle.
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        chk("s_ready_after_reset", 32'(s_ready[0]), 32'd1);

        // Cut-through streaming with the consumer always ready.
        m_ready[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, stream[k], k == 2);
            step();
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        step();
        step();
        chk("stream_drained", 32'(count[0]), 32'd0);

        // Fill under backpressure, single read, then simultaneous write/read.
        m_ready[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive(0, 1'b1, 8'(k), 1'b0);
            step();
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        chk("fill_count", 32'(count[0]), 32'd16);
        chk("fill_s_ready", 32'(s_ready[0]), 32'd0);
        m_ready[0] = 1'b1;
        step();
        m_ready[0] = 1'b0;
        chk("ready_after_read", 32'(s_ready[0]), 32'd1);
        drive(0, 1'b1, 8'hA0, 1'b0);
        m_ready[0] = 1'b1;
        step();
        chk("wr_rd_count", 32'(count[0]), 32'd15);
        drive(0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 16; k++) step();
        chk("fill_drained", 32'(count[0]), 32'd0);

        // Store-and-forward: nothing presented until the last word lands.
        m_ready[1] = 1'b1;
        drive(1, 1'b1, 8'h23, 1'b0);
        step();
        drive(1, 1'b1, 8'h24, 1'b0);
        step();
        drive(1, 1'b0, 8'h00, 1'b0);
        step();
        chk("pkt_partial_valid", 32'(m_valid[1]), 32'd0);
        drive(1, 1'b1, 8'h25, 1'b1);
        step();
        drive(1, 1'b0, 8'h00, 1'b0);
        chk("pkt_whole_valid", 32'(m_valid[1]), 32'd1);
        chk("pkt_whole_count", 32'(pkt_count[1]), 32'd1);
        for (int k = 0; k < 4; k++) step();
        chk("pkt_drained", 32'(pkt_count[1]), 32'd0);

        // Store-and-forward oversize packet: 20 words, no terminator.
        for (int k = 0; k < 20; k++) begin
            drive(1, 1'b1, 8'h30 + 8'(k), 1'b0);
            guard = 0;
            do begin
                acc = exp_ready(1);
                step();
                guard++;
            end while (!acc && guard < 100);
            chk("oversize_accept_timeout", 32'(acc), 32'd1);
        end
        drive(1, 1'b0, 8'h00, 1'b0);
        guard = 0;
        while (sz(1) != 0 && guard < 100) begin
            step();
            guard++;
        end
        chk("oversize_drained", 32'(count[1]), 32'd0);

        // Reset with five stored words, one complete packet.
        m_ready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b1, 8'h50 + 8'(k), k == 4);
            step();
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        chk("pre_reset_pkts", 32'(pkt_count[0]), 32'd1);
        reset = 1'b1;
        #1;
        clear_model();
        chk("rst_count", 32'(count[0]), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count[0]), 32'd0);
        chk("rst_m_valid", 32'(m_valid[0]), 32'd0);
        chk("rst_s_ready", 32'(s_ready[0]), 32'd0);
        step();
        reset = 1'b0;
        step();
        drive(0, 1'b1, 8'h45, 1'b0);
        step();
        drive(0, 1'b0, 8'h00, 1'b0);
        chk("post_reset_head", 32'(m_data[0]), 32'h45);
        chk("post_reset_valid", 32'(m_valid[0]), 32'd1);

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                drive(i, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) == 0);
                m_ready[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
